// File: rtl/rr_arbiter_hold.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_hold
// Purpose  : N-way round-robin arbiter with a registered one-hot grant that
//            is held for a multi-beat transaction. A grant ends on the
//            owner's last beat, on request withdrawal, when the hold-cycle
//            limit forces rotation, or when the arbiter is disabled.
//            Release and re-arbitration happen in the same cycle, so
//            handovers are back-to-back with no idle bubble.
// Ports    : clk          - system clock, rising edge
//            srst_n       - synchronous active-low reset
//            en           - enable; low releases the grant, blocks new ones
//            req_vld[N]   - per-requester request valid
//            req_last[N]  - per-requester last-beat flag (qualified by vld)
//            o_grant[N]   - registered one-hot grant or zero
//            o_grant_idx  - binary index of the grant, 0 when idle
//            o_busy       - high while a grant is active
//            o_grant_cnt  - per-requester grant counters, N*CNT_W bits
//                           (only when RR_ARB_GRANT_CNT_EN is defined)
// Options  : RR_ARB_GRANT_CNT_EN - adds saturating per-requester counters of
//            newly issued grants
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_hold #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 16
) (
  input  logic                          clk,
  input  logic                          srst_n,
  input  logic                          en,
  input  logic [N-1:0]                  req_vld,
  input  logic [N-1:0]                  req_last,
  output logic [N-1:0]                  o_grant,
  output logic [$clog2(N)-1:0]          o_grant_idx,
  output logic                          o_busy
`ifdef RR_ARB_GRANT_CNT_EN
  ,
  output logic [N*CNT_W-1:0]            o_grant_cnt
`endif
);

  localparam int IDX_W = $clog2(N);
  // hold counter only needs to reach MAX_HOLD; keep one bit when unlimited
  localparam int HC_W  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(MAX_HOLD);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  if (N < 2 || N > 32 || CNT_W < 1) begin : g_param_err
    $error("rr_arbiter_hold: illegal parameter (N must be 2..32, CNT_W >= 1)");
  end

  logic [0:0]       state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [HC_W-1:0]  hold_q,  hold_d;
  logic             busy_q,  busy_d;

  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             any_req;
  logic             own_vld;
  logic             own_last;
  logic             hold_at_lim;
  logic             rel_own;
  logic             issue;

  // --------------------------------------------------------------------------
  // Round-robin scan: start just after ptr and wrap; first requester wins.
  // The previous owner is visited last, so it only wins when alone.
  // --------------------------------------------------------------------------
  always_comb begin
    win_idx = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % N);
      if (!any_req && req_vld[cand]) begin
        any_req = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Owner-side release terms. A last beat without valid is not a beat, and
  // only the owner's flags are looked at.
  assign own_vld     = req_vld[idx_q];
  assign own_last    = req_last[idx_q];
  assign hold_at_lim = (MAX_HOLD != 0) && (hold_q == HOLD_LIM);
  assign rel_own     = !own_vld || own_last || hold_at_lim;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= IDX_W'(N - 1);
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    issue   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en && any_req) begin
          issue = 1'b1;
        end
      end
      S_GRANT: begin
        if (!en) begin
          // disable: drop the grant but keep ptr so fairness resumes in place
          state_d = S_IDLE;
          grant_d = '0;
          idx_d   = '0;
          hold_d  = '0;
          busy_d  = 1'b0;
        end else if (rel_own) begin
          // ptr_q already equals the owner, so the scan starts past it
          if (any_req) begin
            issue = 1'b1;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
            idx_d   = '0;
            hold_d  = '0;
            busy_d  = 1'b0;
          end
        end else if (MAX_HOLD != 0) begin
          // cannot overflow: reaching the limit forces a release above
          hold_d = hold_q + HC_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        idx_d   = '0;
        hold_d  = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (issue) begin
      state_d          = S_GRANT;
      grant_d          = '0;
      grant_d[win_idx] = 1'b1;
      idx_d            = win_idx;
      ptr_d            = win_idx;
      hold_d           = HC_W'(1);
      busy_d           = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // --------------------------------------------------------------------------
  always_comb begin
    o_grant     = grant_q;
    o_grant_idx = idx_q;
    o_busy      = busy_q;
  end

`ifdef RR_ARB_GRANT_CNT_EN
  // Counts newly issued grants only; holding an existing grant is not a new one.
  for (genvar i = 0; i < N; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (!srst_n) begin
        cnt_q <= '0;
      end else if (issue && (win_idx == IDX_W'(i)) && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign o_grant_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_hold.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter_hold
// Purpose  : Directed self-checking bench for rr_arbiter_hold with N=4,
//            MAX_HOLD=4, CNT_W=2. Inputs are driven and outputs sampled 1ns
//            after each rising edge; expected values are hand-derived.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_hold;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 2;

  logic         clk;
  logic         srst_n;
  logic         en;
  logic [N-1:0] req_vld;
  logic [N-1:0] req_last;
  logic [N-1:0] o_grant;
  logic [1:0]   o_grant_idx;
  logic         o_busy;
`ifdef RR_ARB_GRANT_CNT_EN
  logic [N*CNT_W-1:0] o_grant_cnt;
`endif

  int checks = 0;
  int passed = 0;

  rr_arbiter_hold #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .srst_n      (srst_n),
    .en          (en),
    .req_vld     (req_vld),
    .req_last    (req_last),
    .o_grant     (o_grant),
    .o_grant_idx (o_grant_idx),
    .o_busy      (o_busy)
`ifdef RR_ARB_GRANT_CNT_EN
    ,
    .o_grant_cnt (o_grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] idx);
    chk({tag, ".grant"}, 32'(o_grant), 32'(g));
    chk({tag, ".idx"},   32'(o_grant_idx), 32'(idx));
    chk({tag, ".busy"},  32'(o_busy), 32'(g != 4'b0000));
  endtask

  initial begin
    srst_n   = 1'b0;
    en       = 1'b1;
    req_vld  = 4'b0000;
    req_last = 4'b0000;
    tick();
    tick();
    chk_grant("reset", 4'b0000, 2'd0);

    // ---- full rotation with single-beat transactions ----------------------
    srst_n   = 1'b1;
    req_vld  = 4'b1111;
    req_last = 4'b1111;
    tick(); chk_grant("rot0", 4'b0001, 2'd0);
    tick(); chk_grant("rot1", 4'b0010, 2'd1);
    tick(); chk_grant("rot2", 4'b0100, 2'd2);
    tick(); chk_grant("rot3", 4'b1000, 2'd3);
    tick(); chk_grant("rot4", 4'b0001, 2'd0);

    // ---- sole requester 2 hits the hold limit and is re-granted -----------
    req_vld  = 4'b0100;
    req_last = 4'b0000;
    tick(); chk_grant("hold_h1", 4'b0100, 2'd2);
    tick(); chk_grant("hold_h2", 4'b0100, 2'd2);
    tick(); chk_grant("hold_h3", 4'b0100, 2'd2);
    tick(); chk_grant("hold_h4", 4'b0100, 2'd2);
    tick(); chk_grant("hold_regrant", 4'b0100, 2'd2);
    // a second requester appears: forced rotation after 4 held cycles
    req_vld = 4'b0101;
    tick(); chk_grant("force_h2", 4'b0100, 2'd2);
    tick(); chk_grant("force_h3", 4'b0100, 2'd2);
    tick(); chk_grant("force_h4", 4'b0100, 2'd2);
    tick(); chk_grant("force_rot", 4'b0001, 2'd0);

    // ---- withdrawal: owner 1 drops, scan from 2 finds 3 -------------------
    req_vld = 4'b0010;
    tick(); chk_grant("own1", 4'b0010, 2'd1);
    req_vld = 4'b1011;
    tick(); chk_grant("own1_hold", 4'b0010, 2'd1);
    req_vld = 4'b1001;
    tick(); chk_grant("withdraw", 4'b1000, 2'd3);

    // ---- disable during a grant, re-enable keeps ptr at 3 -----------------
    en = 1'b0;
    tick(); chk_grant("en_off", 4'b0000, 2'd0);
    tick(); chk_grant("en_off_idle", 4'b0000, 2'd0);
    en = 1'b1;
    tick(); chk_grant("en_on", 4'b0001, 2'd0);

    // ---- reset during a grant to 2 restores ptr=N-1 -----------------------
    req_vld = 4'b0100;
    tick(); chk_grant("pre_rst", 4'b0100, 2'd2);
    srst_n = 1'b0;
    tick(); chk_grant("mid_rst", 4'b0000, 2'd0);
    srst_n  = 1'b1;
    req_vld = 4'b1100;
    tick(); chk_grant("post_rst", 4'b0100, 2'd2);

    // ---- non-owner and unqualified last flags are ignored -----------------
    req_last = 4'b1011;
    tick(); chk_grant("last_ignored", 4'b0100, 2'd2);
    req_last = 4'b0100;
    tick(); chk_grant("last_owner", 4'b1000, 2'd3);

`ifdef RR_ARB_GRANT_CNT_EN
    // ---- grant counters: 5 single-beat grants to 0 saturate at 3 ----------
    srst_n   = 1'b0;
    req_vld  = 4'b0000;
    req_last = 4'b0000;
    tick();
    chk("cnt_reset", 32'(o_grant_cnt), 32'h0);
    srst_n   = 1'b1;
    req_vld  = 4'b0001;
    req_last = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("cnt_grant", 32'(o_grant), 32'h1);
    end
    req_vld = 4'b0000;
    tick();
    chk("cnt0_sat", 32'(o_grant_cnt[1:0]), 32'h3);
    chk("cnt_others", 32'(o_grant_cnt[7:2]), 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_arbiter_hold.md
Name: rr_arbiter_hold

Overview:
- Parametrised N-way round-robin arbiter with a registered one-hot grant.
- Once granted, a requester holds the grant for a multi-beat transaction. The grant ends on the last beat, on request withdrawal, or when a hold-cycle limit forces rotation.
- Sits in front of shared resources (bus master port, memory bank, shared FIFO write side) that need fair access with transaction atomicity.

Parameters:
- N, 4, number of requesters; legal 2..32.
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held; 0 = unlimited.
- CNT_W, 16, width of each per-requester grant counter; used only with the optional feature.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- srst_n  input  1  reset, synchronous, active-low.
- en  input  1  arbiter enable; low forces release and blocks new grants.
- req_vld  input  N  per-requester request valid.
- req_last  input  N  per-requester last-beat flag; meaningful only with the matching req_vld bit.
- o_grant  output  N  registered one-hot grant, or all-zero.
- o_grant_idx  output  $clog2(N)  binary index of the current grant; 0 when o_grant is 0.
- o_busy  output  1  high while o_grant is non-zero.
- o_grant_cnt  output  N*CNT_W  per-requester grant counters; present only with RR_ARB_GRANT_CNT_EN; requester i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (srst_n low at a rising edge):
  - o_grant=0, o_grant_idx=0, o_busy=0, state=IDLE.
  - Priority pointer ptr=N-1, so requester 0 has top priority first.
  - hold_cnt=0; all grant counters=0.
  - Reset mid-grant releases immediately; no release beat is generated.
- Arbitration function:
  - Scan req_vld starting at index (ptr+1) mod N, increasing with wrap.
  - The first set bit wins.
  - If only the previous owner requests, it wins again.
- States: IDLE and GRANT.
- IDLE:
  - If en and |req_vld: next cycle o_grant=onehot(winner), ptr<=winner, hold_cnt<=1, go GRANT.
  - Grant latency is 1 cycle from request to o_grant.
- GRANT, owner g. Release conditions, evaluated each cycle:
  - (a) req_vld[g]=0.
  - (b) req_vld[g]=1 and req_last[g]=1; this cycle is the final beat and the grant is still shown this cycle.
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD while req_vld[g]=1; forced rotation.
  - (d) en=0.
- On release under (a), (b) or (c) with en=1:
  - Re-arbitrate in the same cycle using the current req_vld with ptr=g.
  - If any request is present, the next cycle holds the new one-hot grant (back-to-back, no idle bubble) and hold_cnt<=1.
  - Otherwise o_grant<=0 and go IDLE.
- On release under (d): o_grant<=0, go IDLE; ptr is unchanged.
- No release: o_grant stays, hold_cnt<=hold_cnt+1, saturating at MAX_HOLD. hold_cnt width is $clog2(MAX_HOLD+1), minimum 1.
- Invariants:
  - o_grant is always one-hot or zero.
  - o_grant_idx and o_busy are registered in step with o_grant.
  - req_last with req_vld=0 is ignored.
  - Non-owner req_last is ignored.

Optional Feature:
- Macro: RR_ARB_GRANT_CNT_EN.
- Defined:
  - o_grant_cnt exists.
  - Counter i increments by 1 on each cycle in which a new grant to i is issued (IDLE->GRANT or back-to-back handover). Continued holding does not count.
  - Counters saturate at 2^CNT_W-1.
  - Counters reset to 0 on srst_n low.
- Undefined: the port and the counters are absent; all other behaviour is identical.

Test Plan (N=4, MAX_HOLD=4):
- Reset then req_vld=4'b1111 with req_last=4'b1111 held -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles, back-to-back with no gaps; o_grant_idx 0,1,2,3,0.
- req_vld=4'b0100 held, req_last=0 -> o_grant=0100 for exactly 4 cycles. It is then re-granted to 2 with no gap, because it is the sole requester.
- Owner 1 mid-transaction, req_vld=4'b1011, req_last=0: drop req_vld[1] -> next cycle o_grant=1000 (scan starts at index 2; 2 is not requesting).
- en=0 during a grant to 3 -> o_grant=0 next cycle. en=1 again with req_vld=4'b1001 -> grant 0001 one cycle later (ptr still 3).
- srst_n low for 1 cycle during a grant to 2 -> o_grant=0, o_busy=0. First grant after reset with req_vld=4'b1100 is 0100.
- With RR_ARB_GRANT_CNT_EN and CNT_W=2: 5 single-beat grants to requester 0 -> counter 0 reads 3 (saturated); other counters read 0.
